// File: rtl/operand_fetch.sv
// operand_fetch: decode -> execute operand-fetch stage.
// Drives register-file read addresses, keeps a per-register pending-write
// scoreboard, stalls on read-after-write hazards and registers operands plus
// control into a valid/ready slot for execute.
// Optional feature: define OPFETCH_BYPASS_EN to forward same-cycle writeback
// data and waive the hazard when that writeback retires the last pending write.
module operand_fetch #(
   parameter int CNT_W = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [4:0]  in_rs1,
   input  logic [4:0]  in_rs2,
   input  logic        in_use1,
   input  logic        in_use2,
   input  logic [4:0]  in_rd,
   input  logic        in_rdwe,
   input  logic [31:0] in_pc,
   output logic [4:0]  rf_ra,
   output logic [4:0]  rf_rb,
   input  logic [31:0] rf_busa,
   input  logic [31:0] rf_busb,
   input  logic        wb_we,
   input  logic [4:0]  wb_rw,
   input  logic [31:0] wb_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_a,
   output logic [31:0] out_b,
   output logic [4:0]  out_rd,
   output logic        out_rdwe,
   output logic [31:0] out_pc,
   output logic [15:0] stall_cnt,
   output logic        sb_err
);

`ifdef OPFETCH_BYPASS_EN
   localparam bit BYP_EN = 1'b1;
`else
   localparam bit BYP_EN = 1'b0;
`endif

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Source hazard: pending write on a real source, unless the last one retires now (bypass only).
   function automatic logic src_hazard(input logic used, input logic [4:0] rs,
                                       input logic [CNT_W-1:0] c, input logic we,
                                       input logic [4:0] rw);
      logic waive;
      waive = BYP_EN && (c == CNT_W'(1)) && we && (rw == rs);
      return used && (rs != 5'd0) && (c != '0) && !waive;
   endfunction

   // Operand select: x0 reads zero, same-cycle writeback wins when forwarding is built in.
   function automatic logic [31:0] sel_operand(input logic [4:0] rs, input logic [31:0] bus,
                                               input logic we, input logic [4:0] rw,
                                               input logic [31:0] wdata);
      if (rs == 5'd0) return 32'd0;
      if (BYP_EN && we && (rw == rs)) return wdata;
      return bus;
   endfunction

   // Counter update: +inc -dec, floored at zero (covers stray writebacks and flush+wb on one reg).
   function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c, input logic inc,
                                                 input logic [1:0] dec);
      int v;
      v = int'(c) + int'(inc) - int'(dec);
      if (v < 0) v = 0;
      return CNT_W'(v);
   endfunction

   logic [CNT_W-1:0] cnt_q [32];
   logic [CNT_W-1:0] cnt_d [32];

   logic        out_valid_q, out_valid_d;
   logic [31:0] out_a_q, out_b_q, out_pc_q;
   logic [4:0]  out_rd_q;
   logic        out_rdwe_q;
   logic [15:0] stall_q, stall_d;
   logic        sb_err_q, sb_err_d;

   logic haz_a, haz_b, haz_full, hazard, accept, flush_kill;
   logic [31:0] op_a, op_b;

   assign rf_ra = in_rs1;
   assign rf_rb = in_rs2;

   // Hazard detection, handshake and operand selection for the presented instruction.
   always_comb begin
      haz_a    = src_hazard(in_use1, in_rs1, cnt_q[in_rs1], wb_we, wb_rw);
      haz_b    = src_hazard(in_use2, in_rs2, cnt_q[in_rs2], wb_we, wb_rw);
      haz_full = in_rdwe && (in_rd != 5'd0) && (cnt_q[in_rd] == CNT_MAX);
      hazard   = haz_a || haz_b || haz_full;
      in_ready = (!out_valid_q || out_ready) && !hazard && !flush;
      accept   = in_valid && in_ready;
      op_a     = sel_operand(in_rs1, rf_busa, wb_we, wb_rw, wb_data);
      op_b     = sel_operand(in_rs2, rf_busb, wb_we, wb_rw, wb_data);
      // A flushed slot's write will never retire, so its pending count is returned.
      flush_kill = flush && out_valid_q && out_rdwe_q;
   end

   // Scoreboard, slot-valid, stall counter and error flag next state.
   always_comb begin
      cnt_d[0] = '0;
      for (int r = 1; r < 32; r++) begin
         cnt_d[r] = cnt_next(cnt_q[r],
                             accept && in_rdwe && (in_rd == 5'(r)),
                             2'(wb_we && (wb_rw == 5'(r))) +
                             2'(flush_kill && (out_rd_q == 5'(r))));
      end

      out_valid_d = out_valid_q;
      if (flush)          out_valid_d = 1'b0;
      else if (accept)    out_valid_d = 1'b1;
      else if (out_ready) out_valid_d = 1'b0;

      stall_d = stall_q;
      if (in_valid && hazard && !flush && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;

      sb_err_d = sb_err_q;
      if (wb_we && (wb_rw != 5'd0) && (cnt_q[wb_rw] == '0)) sb_err_d = 1'b1;
   end

   // Control state: scoreboard, slot valid, stall counter, sticky error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < 32; r++) cnt_q[r] <= '0;
         out_valid_q <= 1'b0;
         stall_q     <= '0;
         sb_err_q    <= 1'b0;
      end else begin
         for (int r = 0; r < 32; r++) cnt_q[r] <= cnt_d[r];
         out_valid_q <= out_valid_d;
         stall_q     <= stall_d;
         sb_err_q    <= sb_err_d;
      end
   end

   // Output slot payload: loads on accept, otherwise holds.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_a_q    <= '0;
         out_b_q    <= '0;
         out_rd_q   <= '0;
         out_rdwe_q <= 1'b0;
         out_pc_q   <= '0;
      end else if (accept) begin
         out_a_q    <= op_a;
         out_b_q    <= op_b;
         out_rd_q   <= in_rd;
         out_rdwe_q <= in_rdwe;
         out_pc_q   <= in_pc;
      end
   end

   assign out_valid = out_valid_q;
   assign out_a     = out_a_q;
   assign out_b     = out_b_q;
   assign out_rd    = out_rd_q;
   assign out_rdwe  = out_rdwe_q;
   assign out_pc    = out_pc_q;
   assign stall_cnt = stall_q;
   assign sb_err    = sb_err_q;

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed stimulus for operand_fetch, a behavioural
// scoreboard model compared every cycle, plus literal spot checks.
module tb_operand_fetch;

`ifdef OPFETCH_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   localparam int CNT_W = 2;
   localparam int MAXC  = (1 << CNT_W) - 1;
   localparam int S1    = BYP ? 1 : 2;

   logic        clk, rst, flush;
   logic        in_valid, in_ready;
   logic [4:0]  in_rs1, in_rs2, in_rd;
   logic        in_use1, in_use2, in_rdwe;
   logic [31:0] in_pc;
   logic [4:0]  rf_ra, rf_rb;
   logic [31:0] rf_busa, rf_busb;
   logic        wb_we;
   logic [4:0]  wb_rw;
   logic [31:0] wb_data;
   logic        out_valid, out_ready;
   logic [31:0] out_a, out_b, out_pc;
   logic [4:0]  out_rd;
   logic        out_rdwe;
   logic [15:0] stall_cnt;
   logic        sb_err;

   int n_tests = 0;
   int n_fail  = 0;

   operand_fetch #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use1(in_use1), .in_use2(in_use2),
      .in_rd(in_rd), .in_rdwe(in_rdwe), .in_pc(in_pc),
      .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_busa(rf_busa), .rf_busb(rf_busb),
      .wb_we(wb_we), .wb_rw(wb_rw), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_a(out_a), .out_b(out_b), .out_rd(out_rd), .out_rdwe(out_rdwe),
      .out_pc(out_pc), .stall_cnt(stall_cnt), .sb_err(sb_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bench register file: async read, write at the edge; x0 holds junk the DUT must ignore.
   logic [31:0] rf [32];
   assign rf_busa = rf[rf_ra];
   assign rf_busb = rf[rf_rb];
   always @(posedge clk) begin
      if (rst) begin
         rf[0] <= 32'hDEAD_BEEF;
         for (int i = 1; i < 32; i++) rf[i] <= 32'hA000_0000 + i;
      end else if (wb_we && wb_rw != 5'd0) begin
         rf[wb_rw] <= wb_data;
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Behavioural model state
   int          pend [32];
   bit          m_valid;
   logic [31:0] m_a, m_b, m_pc;
   logic [4:0]  m_rd;
   bit          m_rdwe;
   int          m_stall;
   bit          m_err;

   function automatic bit src_haz(input logic u, input logic [4:0] rs);
      if (!u || rs == 0 || pend[rs] == 0) return 0;
      if (BYP && pend[rs] == 1 && wb_we && wb_rw == rs) return 0;
      return 1;
   endfunction

   function automatic logic [31:0] exp_op(input logic [4:0] rs);
      if (rs == 0) return 32'd0;
      if (BYP && wb_we && wb_rw == rs) return wb_data;
      return rf[rs];
   endfunction

   always @(negedge clk) begin : model_cmp
      bit hz, rdy, acc;
      int d;
      if (rst) begin
         for (int r = 0; r < 32; r++) pend[r] = 0;
         m_valid = 0; m_a = 0; m_b = 0; m_pc = 0; m_rd = 0; m_rdwe = 0;
         m_stall = 0; m_err = 0;
      end
      hz  = src_haz(in_use1, in_rs1) || src_haz(in_use2, in_rs2) ||
            (in_rdwe && in_rd != 0 && pend[in_rd] == MAXC);
      rdy = (!m_valid || out_ready) && !hz && !flush;
      acc = in_valid && rdy;
      check("in_ready", {31'd0, in_ready}, {31'd0, rdy});
      check("rf_ra", {27'd0, rf_ra}, {27'd0, in_rs1});
      check("rf_rb", {27'd0, rf_rb}, {27'd0, in_rs2});
      check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      check("out_a", out_a, m_a);
      check("out_b", out_b, m_b);
      check("out_rd", {27'd0, out_rd}, {27'd0, m_rd});
      check("out_rdwe", {31'd0, out_rdwe}, {31'd0, m_rdwe});
      check("out_pc", out_pc, m_pc);
      check("stall_cnt", {16'd0, stall_cnt}, m_stall);
      check("sb_err", {31'd0, sb_err}, {31'd0, m_err});
      if (!rst) begin
         if (in_valid && hz && !flush && m_stall < 65535) m_stall++;
         if (wb_we && wb_rw != 0 && pend[wb_rw] == 0) m_err = 1;
         for (int r = 1; r < 32; r++) begin
            d = 0;
            if (acc && in_rdwe && in_rd == r) d++;
            if (wb_we && wb_rw == r) d--;
            if (flush && m_valid && m_rdwe && m_rd == r) d--;
            pend[r] = (pend[r] + d < 0) ? 0 : pend[r] + d;
         end
         if (flush) m_valid = 0;
         else if (acc) begin
            m_valid = 1; m_a = exp_op(in_rs1); m_b = exp_op(in_rs2);
            m_rd = in_rd; m_rdwe = in_rdwe; m_pc = in_pc;
         end else if (out_ready) m_valid = 0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic we, input logic [31:0] pc);
      in_valid = v; in_rs1 = rs1; in_rs2 = rs2; in_use1 = u1; in_use2 = u2;
      in_rd = rd; in_rdwe = we; in_pc = pc;
   endtask

   task automatic set_wb(input logic we, input logic [4:0] rw, input logic [31:0] data);
      wb_we = we; wb_rw = rw; wb_data = data;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      set_wb(0, 0, 0);
      tick(); tick();
      check("lit_rst_valid", {31'd0, out_valid}, 32'd0);
      check("lit_rst_stall", {16'd0, stall_cnt}, 32'd0);
      check("lit_rst_out_a", out_a, 32'd0);
      rst = 1'b0;
      tick();

      // Dependent pair on x5
      set_in(1, 1, 2, 1, 1, 5, 1, 32'h100);
      #1 check("lit_dep_first_ready", {31'd0, in_ready}, 32'd1);
      tick();
      check("lit_dep_first_a", out_a, 32'hA000_0001);
      check("lit_dep_first_pc", out_pc, 32'h100);
      set_in(1, 5, 0, 1, 0, 6, 1, 32'h104);
      #1 check("lit_dep_stall_ready", {31'd0, in_ready}, 32'd0);
      tick();
      check("lit_dep_stall1", {16'd0, stall_cnt}, 32'd1);
      set_wb(1, 5, 32'h1234);
      #1;
      if (BYP) begin
         check("lit_dep_byp_ready", {31'd0, in_ready}, 32'd1);
         tick();
         set_wb(0, 0, 0); in_valid = 0;
      end else begin
         check("lit_dep_nobyp_ready", {31'd0, in_ready}, 32'd0);
         tick();
         set_wb(0, 0, 0);
         #1 check("lit_dep_nobyp_ready2", {31'd0, in_ready}, 32'd1);
         tick();
         in_valid = 0;
      end
      check("lit_dep_a", out_a, 32'h1234);
      check("lit_dep_stall", {16'd0, stall_cnt}, S1);
      set_wb(1, 6, 32'h66);
      tick();
      set_wb(0, 0, 0);
      tick();

      // x0 source and destination
      set_in(1, 0, 0, 1, 1, 0, 1, 32'h200);
      #1 check("lit_x0_ready", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 0;
      check("lit_x0_a", out_a, 32'd0);
      check("lit_x0_rd", {27'd0, out_rd}, 32'd0);
      tick();

      // Counter full on x7
      for (int i = 0; i < 3; i++) begin
         set_in(1, 0, 0, 0, 0, 7, 1, 32'h300 + 4 * i);
         tick();
      end
      set_in(1, 0, 0, 0, 0, 7, 1, 32'h30C);
      #1 check("lit_full_ready", {31'd0, in_ready}, 32'd0);
      tick();
      set_wb(1, 7, 32'h77);
      #1 check("lit_full_wb_ready", {31'd0, in_ready}, 32'd0);
      tick();
      set_wb(0, 0, 0);
      #1 check("lit_full_after_ready", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 0;
      check("lit_full_pc", out_pc, 32'h30C);
      check("lit_full_stall", {16'd0, stall_cnt}, S1 + 2);
      set_wb(1, 7, 32'h77);
      tick(); tick(); tick();
      set_wb(0, 0, 0);
      tick();

      // Flush with slot holding rd=9
      out_ready = 0;
      set_in(1, 0, 0, 0, 0, 9, 1, 32'h400);
      tick();
      in_valid = 0;
      check("lit_fl_rd", {27'd0, out_rd}, 32'd9);
      flush = 1;
      tick();
      flush = 0;
      check("lit_fl_valid", {31'd0, out_valid}, 32'd0);
      set_in(1, 9, 0, 1, 0, 0, 0, 32'h404);
      #1 check("lit_fl_read_ready", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 0;
      check("lit_fl_read_a", out_a, 32'hA000_0009);
      out_ready = 1;
      tick();

      // Flush together with a writeback to the same register
      out_ready = 0;
      set_in(1, 0, 0, 0, 0, 10, 1, 32'h600);
      tick();
      in_valid = 0;
      flush = 1; set_wb(1, 10, 32'hAA);
      tick();
      flush = 0; set_wb(0, 0, 0);
      out_ready = 1;
      tick();

      // Backpressure
      out_ready = 0;
      set_in(1, 1, 0, 1, 0, 0, 0, 32'h500);
      tick();
      set_in(1, 2, 0, 1, 0, 0, 0, 32'h504);
      for (int i = 0; i < 3; i++) begin
         #1;
         check("lit_bp_pc", out_pc, 32'h500);
         check("lit_bp_ready", {31'd0, in_ready}, 32'd0);
         tick();
      end
      out_ready = 1;
      #1 check("lit_bp_release_ready", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 0;
      check("lit_bp_pc2", out_pc, 32'h504);
      check("lit_bp_a2", out_a, 32'hA000_0002);
      tick();

      // Stray writeback to x3
      set_wb(1, 3, 32'h0);
      tick();
      set_wb(0, 0, 0);
      check("lit_sb_err", {31'd0, sb_err}, 32'd1);
      tick(); tick();
      check("lit_sb_err_sticky", {31'd0, sb_err}, 32'd1);

      // Asynchronous reset mid-operation
      out_ready = 0;
      set_in(1, 0, 0, 0, 0, 11, 1, 32'h800);
      tick();
      in_valid = 0;
      rst = 1;
      #1;
      check("lit_arst_valid", {31'd0, out_valid}, 32'd0);
      check("lit_arst_err", {31'd0, sb_err}, 32'd0);
      check("lit_arst_stall", {16'd0, stall_cnt}, 32'd0);
      tick();
      rst = 0;
      out_ready = 1;
      tick();

      // Back-to-back flow
      for (int i = 0; i < 4; i++) begin
         set_in(1, 5'(i + 1), 5'(i + 2), 1, 1, 0, 0, 32'h700 + 4 * i);
         tick();
         check("lit_b2b_pc", out_pc, 32'h700 + 4 * i);
         check("lit_b2b_valid", {31'd0, out_valid}, 32'd1);
      end
      in_valid = 0;
      tick();
      check("lit_b2b_drain", {31'd0, out_valid}, 32'd0);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Operand-fetch stage between decode and execute, wrapped around the register file. Drives the register file read addresses, tracks outstanding destination writes per register with a scoreboard, and stalls on read-after-write hazards. Forwards same-cycle writeback data and registers the operands, plus control, into a valid/ready output slot for execute.

## Interface

Parameters:
- CNT_W, 2: width of each per-register pending-write counter; maximum in-flight writes per register is 2^CNT_W-1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  kill the instruction held in the output slot and block acceptance this cycle.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_rs1, in_rs2  in  5  source register indices.
- in_use1, in_use2  in  1  source actually read.
- in_rd  in  5  destination index.
- in_rdwe  in  1  instruction writes in_rd.
- in_pc  in  32  instruction PC, passed through.
- rf_ra, rf_rb  out  5  register-file read addresses; equal to in_rs1/in_rs2 combinationally.
- rf_busa, rf_busb  in  32  register-file asynchronous read data.
- wb_we  in  1  writeback valid; the same strobe drives the register-file write port.
- wb_rw  in  5  writeback register.
- wb_data  in  32  writeback data.
- out_valid  out  1  output slot holds an instruction.
- out_ready  in  1  execute consumes the slot.
- out_a, out_b  out  32  operands.
- out_rd  out  5  destination index.
- out_rdwe  out  1  destination write enable.
- out_pc  out  32  instruction PC.
- stall_cnt  out  16  saturating count of hazard-stall cycles.
- sb_err  out  1  sticky; set on writeback to a register whose counter is 0.

## Operation

- Scoreboard: cnt[1..31], each CNT_W bits wide. Register x0 is never tracked; reads of x0 return 0.
- accept = in_valid & in_ready.
- Increment cnt[in_rd] on accept when in_rdwe=1 and in_rd≠0.
- Decrement cnt[wb_rw] when wb_we=1 and wb_rw≠0. A writeback that hits cnt=0 leaves the counter at 0 and sets sb_err.
- Increment and decrement on the same register in the same cycle leave the counter unchanged.
- Hazard for source s: in_use=1, rs≠0, and cnt[rs]>0. With bypass compiled in, the hazard is waived when cnt[rs]=1 and wb_we=1 and wb_rw=rs.
- Full: cnt[in_rd]=max with in_rdwe=1 and in_rd≠0 is also a hazard.
- in_ready = (!out_valid | out_ready) & !hazard & !flush.
- Operand select, per source: 0 if rs=0; wb_data if bypass is enabled and wb_we=1 and wb_rw=rs; otherwise rf_bus.
- Output slot:
  - Loads on accept and sets out_valid.
  - Clears out_valid when out_ready=1 without a new accept.
  - Holds all fields while out_valid=1 and out_ready=0.
- Flush:
  - Clears out_valid.
  - If the slot held out_rdwe=1 and out_rd≠0, decrements cnt[out_rd], because that write will never retire. A simultaneous writeback decrement to the same register applies too; a net change of -2 saturates at 0.
  - No accept occurs in the flush cycle.
- stall_cnt increments in every cycle where in_valid=1 and hazard=1 and flush=0; it saturates at 0xFFFF.

## Timing

- Reset state: all cnt=0, out_valid=0, out_a=out_b=0, out_rd=0, out_rdwe=0, out_pc=0, stall_cnt=0, sb_err=0.
- in_ready, rf_ra and rf_rb are combinational.
- Latency: accept at edge N drives out_valid=1 and the operands after edge N.
- The register file writes at the edge, so data written at edge N is visible on rf_bus in cycle N+1 without bypass.
- Back-to-back: with out_ready held at 1 and no hazards, one instruction moves through per cycle.
- Reset mid-operation clears the slot and the scoreboard immediately, without waiting for a clock edge.

## Configuration

- OPFETCH_BYPASS_EN defined:
  - Same-cycle wb_data forwarding is active.
  - The hazard waiver for cnt=1 with a matching writeback applies.
- OPFETCH_BYPASS_EN undefined:
  - Operands come from rf_bus or 0 only.
  - Any cnt>0 stalls, so a dependent instruction issues one cycle after the writeback that clears it.

## Test plan

- Dependent pair: issue rd=5, then an instruction using rs1=5 → in_ready=0 and stall_cnt increments. Writeback x5=0x1234 → with bypass: accepted in that cycle, out_a=0x1234. Without bypass: accepted in the next cycle, out_a=0x1234.
- x0: in_rs1=0, in_rd=0 with in_rdwe=1 → never stalls, out_a=0, no counter changes.
- Counter full, CNT_W=2: three issues to rd=7 → a fourth issue to rd=7 stalls until one writeback of x7.
- Flush with slot holding rd=9 → out_valid=0 and cnt[9] returns to 0. A later read of x9 does not stall.
- Backpressure: out_ready=0 for 3 cycles → out_* stable and in_ready=0. Release → next instruction accepted in the same cycle.
- Stray writeback to x3 with cnt[3]=0 → sb_err=1 and stays 1 until rst.
